// File: rtl/grating_position_counter.sv
// rtl/grating_position_counter.sv - circular grating absolute position / revolution counter
// Homes on the first index pulse, then checks every later index against the count.
module grating_position_counter #(
    parameter int LINES_PER_REV = 2500,
    parameter int POS_W         = 16,
    parameter int REV_W         = 16,
    parameter int IDX_TOL       = 2
) (
    input  logic             CLOCK_50M,
    input  logic             RST,
    input  logic             iCount_Pulse,
    input  logic             iCorotation,
    input  logic             iIndex_Pulse,
    input  logic             iRd_Req,
    input  logic             iErr_Clr,
    output logic [POS_W-1:0] oPosition,
    output logic [REV_W-1:0] oRev_Count,
    output logic             oHomed,
    output logic             oIndex_Err,
    output logic             oRd_Valid,
    output logic [POS_W-1:0] oPosition_Snap,
    output logic [REV_W-1:0] oRev_Snap
);

    localparam int CPR = 4 * LINES_PER_REV;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);
    localparam logic [POS_W:0]   CPR_W   = (POS_W+1)'(CPR);
    localparam logic [POS_W:0]   TOL_W   = (POS_W+1)'(IDX_TOL);

    typedef enum logic {UNREF, REFD} state_t;
    state_t state;

    logic [POS_W-1:0] posNext;
    logic [REV_W-1:0] revNext;
    logic [POS_W-1:0] posFinal;
    logic [REV_W-1:0] revFinal;
    logic [POS_W:0]   distUp;
    logic [POS_W:0]   distDown;
    logic [POS_W:0]   indexDist;
    logic             errSet;

    always_comb begin
        posNext = oPosition;
        revNext = oRev_Count;
        if (iCount_Pulse) begin
            if (iCorotation) begin
                if (oPosition == POS_MAX) begin
                    posNext = '0;
                    revNext = oRev_Count + 1'b1;
                end else begin
                    posNext = oPosition + 1'b1;
                end
            end else begin
                if (oPosition == '0) begin
                    posNext = POS_MAX;
                    revNext = oRev_Count - 1'b1;
                end else begin
                    posNext = oPosition - 1'b1;
                end
            end
        end
    end

    // Distance of the stepped position from zero, measured the short way round.
    always_comb begin
        distUp    = {1'b0, posNext};
        distDown  = CPR_W - distUp;
        indexDist = (distUp < distDown) ? distUp : distDown;
        errSet    = iIndex_Pulse && (state == REFD) && (indexDist > TOL_W);
    end

    always_comb begin
        posFinal = posNext;
        revFinal = revNext;
        if (iIndex_Pulse) begin
            posFinal = '0;
            if (state == UNREF) begin
                revFinal = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50M) begin
        if (RST) begin
            state          <= UNREF;
            oPosition      <= '0;
            oRev_Count     <= '0;
            oHomed         <= 1'b0;
            oIndex_Err     <= 1'b0;
            oRd_Valid      <= 1'b0;
            oPosition_Snap <= '0;
            oRev_Snap      <= '0;
        end else begin
            oPosition  <= posFinal;
            oRev_Count <= revFinal;
            oRd_Valid  <= iRd_Req;
            if (iRd_Req) begin
                oPosition_Snap <= posFinal;
                oRev_Snap      <= revFinal;
            end
            if (iIndex_Pulse && state == UNREF) begin
                state  <= REFD;
                oHomed <= 1'b1;
            end
            // A new error in the same cycle as a clear must not be lost.
            if (errSet) begin
                oIndex_Err <= 1'b1;
            end else if (iErr_Clr) begin
                oIndex_Err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_grating_position_counter.sv
// tb/tb_grating_position_counter.sv - directed bench for grating_position_counter
module tb_grating_position_counter;

    logic        CLOCK_50M = 1'b0;
    logic        RST = 1'b1;
    logic        iCount_Pulse = 1'b0;
    logic        iCorotation = 1'b1;
    logic        iIndex_Pulse = 1'b0;
    logic        iRd_Req = 1'b0;
    logic        iErr_Clr = 1'b0;
    logic [15:0] oPosition;
    logic [15:0] oRev_Count;
    logic        oHomed;
    logic        oIndex_Err;
    logic        oRd_Valid;
    logic [15:0] oPosition_Snap;
    logic [15:0] oRev_Snap;

    int nAsserts = 0;
    int nFails = 0;

    grating_position_counter dut (
        .CLOCK_50M      (CLOCK_50M),
        .RST            (RST),
        .iCount_Pulse   (iCount_Pulse),
        .iCorotation    (iCorotation),
        .iIndex_Pulse   (iIndex_Pulse),
        .iRd_Req        (iRd_Req),
        .iErr_Clr       (iErr_Clr),
        .oPosition      (oPosition),
        .oRev_Count     (oRev_Count),
        .oHomed         (oHomed),
        .oIndex_Err     (oIndex_Err),
        .oRd_Valid      (oRd_Valid),
        .oPosition_Snap (oPosition_Snap),
        .oRev_Snap      (oRev_Snap)
    );

    always #10 CLOCK_50M = ~CLOCK_50M;

    task automatic tick();
        @(posedge CLOCK_50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input logic dir, input int n);
        iCorotation  = dir;
        iCount_Pulse = 1'b1;
        repeat (n) tick();
        iCount_Pulse = 1'b0;
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_pos"},   oPosition,      0);
        chk({tag, "_rev"},   oRev_Count,     0);
        chk({tag, "_homed"}, oHomed,         0);
        chk({tag, "_err"},   oIndex_Err,     0);
        chk({tag, "_valid"}, oRd_Valid,      0);
        chk({tag, "_psnap"}, oPosition_Snap, 0);
        chk({tag, "_rsnap"}, oRev_Snap,      0);
    endtask

    initial begin
        doReset();
        chkAllZero("reset");

        // T1 up-wrap from 9998
        pulses(1'b1, 9998);
        chk("t1_start_pos", oPosition, 9998);
        iCount_Pulse = 1'b1;
        tick();
        chk("t1_p1_pos", oPosition, 9999);
        chk("t1_p1_rev", oRev_Count, 0);
        tick();
        chk("t1_p2_pos", oPosition, 0);
        chk("t1_p2_rev", oRev_Count, 1);
        tick();
        chk("t1_p3_pos", oPosition, 1);
        chk("t1_p3_rev", oRev_Count, 1);
        iCount_Pulse = 1'b0;
        tick();
        chk("t1_idle_pos", oPosition, 1);

        // T2 down-wrap from reset
        doReset();
        pulses(1'b0, 1);
        chk("t2_pos", oPosition, 9999);
        chk("t2_rev", oRev_Count, 16'hFFFF);
        chk("t2_homed", oHomed, 0);

        // T3 homing
        doReset();
        pulses(1'b1, 123);
        chk("t3_pre_pos", oPosition, 123);
        iIndex_Pulse = 1'b1;
        tick();
        iIndex_Pulse = 1'b0;
        chk("t3_pos", oPosition, 0);
        chk("t3_rev", oRev_Count, 0);
        chk("t3_homed", oHomed, 1);
        chk("t3_err", oIndex_Err, 0);

        // T4 index check, outside tolerance
        pulses(1'b1, 10003);
        chk("t4a_pre_pos", oPosition, 3);
        chk("t4a_pre_rev", oRev_Count, 1);
        iIndex_Pulse = 1'b1;
        tick();
        iIndex_Pulse = 1'b0;
        chk("t4a_err", oIndex_Err, 1);
        chk("t4a_pos", oPosition, 0);
        chk("t4a_rev", oRev_Count, 1);
        tick();
        chk("t4a_err_sticky", oIndex_Err, 1);
        iErr_Clr = 1'b1;
        tick();
        iErr_Clr = 1'b0;
        chk("t4a_clr", oIndex_Err, 0);

        // within tolerance, upper side
        pulses(1'b1, 10002);
        chk("t4b_pre_pos", oPosition, 2);
        iIndex_Pulse = 1'b1;
        tick();
        iIndex_Pulse = 1'b0;
        chk("t4b_err", oIndex_Err, 0);
        chk("t4b_pos", oPosition, 0);
        chk("t4b_rev", oRev_Count, 2);

        // within tolerance, lower side
        pulses(1'b0, 2);
        chk("t4c_pre_pos", oPosition, 9998);
        chk("t4c_pre_rev", oRev_Count, 1);
        iIndex_Pulse = 1'b1;
        tick();
        iIndex_Pulse = 1'b0;
        chk("t4c_err", oIndex_Err, 0);
        chk("t4c_rev", oRev_Count, 1);

        // outside tolerance on lower side, with clear in the same cycle
        pulses(1'b0, 3);
        chk("t4d_pre_pos", oPosition, 9997);
        iIndex_Pulse = 1'b1;
        iErr_Clr = 1'b1;
        tick();
        iIndex_Pulse = 1'b0;
        iErr_Clr = 1'b0;
        chk("t4d_set_wins", oIndex_Err, 1);
        chk("t4d_rev", oRev_Count, 0);
        iErr_Clr = 1'b1;
        tick();
        iErr_Clr = 1'b0;
        chk("t4d_clr", oIndex_Err, 0);

        // T5 simultaneous pulse + index + read request at 9999
        pulses(1'b1, 9999);
        chk("t5_pre_pos", oPosition, 9999);
        chk("t5_pre_rev", oRev_Count, 0);
        iCorotation  = 1'b1;
        iCount_Pulse = 1'b1;
        iIndex_Pulse = 1'b1;
        iRd_Req      = 1'b1;
        tick();
        iCount_Pulse = 1'b0;
        iIndex_Pulse = 1'b0;
        iRd_Req      = 1'b0;
        chk("t5_pos", oPosition, 0);
        chk("t5_rev", oRev_Count, 1);
        chk("t5_err", oIndex_Err, 0);
        chk("t5_valid", oRd_Valid, 1);
        chk("t5_psnap", oPosition_Snap, 0);
        chk("t5_rsnap", oRev_Snap, 1);
        tick();
        chk("t5_valid_drop", oRd_Valid, 0);

        // back-to-back snapshot requests during counting
        iCount_Pulse = 1'b1;
        iRd_Req      = 1'b1;
        tick();
        chk("b2b_valid1", oRd_Valid, 1);
        chk("b2b_psnap1", oPosition_Snap, 1);
        tick();
        iRd_Req = 1'b0;
        chk("b2b_valid2", oRd_Valid, 1);
        chk("b2b_psnap2", oPosition_Snap, 2);
        tick();
        iCount_Pulse = 1'b0;
        chk("b2b_valid3", oRd_Valid, 0);
        chk("b2b_hold", oPosition_Snap, 2);
        chk("b2b_pos", oPosition, 3);
        chk("b2b_rsnap", oRev_Snap, 1);

        // T6 reset mid-run with pulse train active
        chk("t6_pre_homed", oHomed, 1);
        iCount_Pulse = 1'b1;
        iIndex_Pulse = 1'b1;
        iRd_Req      = 1'b1;
        RST          = 1'b1;
        tick();
        RST          = 1'b0;
        iIndex_Pulse = 1'b0;
        iRd_Req      = 1'b0;
        iCount_Pulse = 1'b0;
        chkAllZero("t6");

        // back in UNREF: far-off index homes without raising an error
        pulses(1'b1, 5);
        chk("t6_unref_pos", oPosition, 5);
        iIndex_Pulse = 1'b1;
        tick();
        iIndex_Pulse = 1'b0;
        chk("t6_unref_err", oIndex_Err, 0);
        chk("t6_rehomed", oHomed, 1);
        chk("t6_rehome_pos", oPosition, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
